// File: rtl/alu_pkg.sv
// Shared definitions for the queued sequential ALU: opcodes, FSM states,
// flag bit positions and a small opcode classification helper.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    localparam int FLAG_CARRY   = 0;
    localparam int FLAG_ZERO    = 1;
    localparam int FLAG_DIV0    = 2;
    localparam int FLAG_ILLEGAL = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/queued_seq_alu_if.sv
// Command and result handshake bundle; master is the environment, slave is the ALU.
interface queued_seq_alu_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               opcode;
    logic [WIDTH-1:0]         in1;
    logic [WIDTH-1:0]         in2;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_high;
    logic [WIDTH-1:0]         out_low;
    logic [3:0]               flags;
    logic [$clog2(DEPTH):0]   count;
    logic                     busy;

    modport master (
        output in_valid, opcode, in1, in2, out_ready,
        input  in_ready, out_valid, out_high, out_low, flags, count, busy
    );

    modport slave (
        input  in_valid, opcode, in1, in2, out_ready,
        output in_ready, out_valid, out_high, out_low, flags, count, busy
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Show-ahead synchronous command FIFO with occupancy count; push and pop
// on the same edge leave the count unchanged.
module alu_cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/queued_seq_alu.sv
// Multi-cycle ALU behind a command FIFO: pops one command at a time, runs it
// (shift-add MUL, restoring DIV, single-edge simple ops) and holds the result.
module queued_seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    queued_seq_alu_if.slave bus
);
    localparam int DW = 3 + 2 * WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_high_q, out_high_d;
    logic [WIDTH-1:0] out_low_q, out_low_d;
    logic [3:0]       flags_q, flags_d;

    logic [DW-1:0]    head_s;
    logic [2:0]       head_op_s;
    logic [WIDTH-1:0] head_a_s, head_b_s;
    logic             fifo_full_s, fifo_empty_s, pop_s, latch_s;
    logic [CW-1:0]    fifo_count_s;

    logic [WIDTH:0]   add_s, sub_s, mul_sum_s, div_shift_s;
    logic [WIDTH-1:0] mul_hi_s, mul_lo_s, div_rem_s, div_quo_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] fin_hi_s, fin_lo_s;
    logic [3:0]       fin_flags_s;

    assign pop_s = (state_q == ST_IDLE) && !fifo_empty_s;

    alu_cmd_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.in_valid),
        .pop_i   (pop_s),
        .wdata_i ({bus.opcode, bus.in1, bus.in2}),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign head_op_s = head_s[DW-1 -: 3];
    assign head_a_s  = head_s[2*WIDTH-1 -: WIDTH];
    assign head_b_s  = head_s[WIDTH-1:0];

    // MUL keeps {hi,lo} as {partial product, remaining multiplier}; DIV as {remainder, quotient}
    assign add_s       = {1'b0, a_q} + {1'b0, b_q};
    assign sub_s       = {1'b0, a_q} - {1'b0, b_q};
    assign mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_hi_s    = mul_sum_s[WIDTH:1];
    assign mul_lo_s    = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    assign div_shift_s = {hi_q, lo_q[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, b_q});
    assign div_rem_s   = div_ge_s ? (div_shift_s[WIDTH-1:0] - b_q) : div_shift_s[WIDTH-1:0];
    assign div_quo_s   = {lo_q[WIDTH-2:0], div_ge_s};

    // Final result and flags, meaningful on the edge that enters RESULT
    always_comb begin
        fin_hi_s    = '0;
        fin_lo_s    = '0;
        fin_flags_s = 4'b0000;
        case (op_q)
            OP_ADD: begin
                fin_lo_s                 = add_s[WIDTH-1:0];
                fin_hi_s                 = {{(WIDTH-1){1'b0}}, add_s[WIDTH]};
                fin_flags_s[FLAG_CARRY]  = add_s[WIDTH];
            end
            OP_SUB: begin
                fin_lo_s                 = sub_s[WIDTH-1:0];
                fin_hi_s                 = {{(WIDTH-1){1'b0}}, sub_s[WIDTH]};
                fin_flags_s[FLAG_CARRY]  = sub_s[WIDTH];
            end
            OP_MUL: begin
                fin_hi_s = mul_hi_s;
                fin_lo_s = mul_lo_s;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    fin_hi_s               = a_q;
                    fin_lo_s               = '1;
                    fin_flags_s[FLAG_DIV0] = 1'b1;
                end else begin
                    fin_hi_s = div_rem_s;
                    fin_lo_s = div_quo_s;
                end
            end
            OP_AND:  fin_lo_s = a_q & b_q;
            OP_OR:   fin_lo_s = a_q | b_q;
            OP_XOR:  fin_lo_s = a_q ^ b_q;
            default: fin_flags_s[FLAG_ILLEGAL] = 1'b1;
        endcase
        fin_flags_s[FLAG_ZERO] = (op_q != OP_ILL) && ({fin_hi_s, fin_lo_s} == '0);
    end

    // FSM next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        iter_d      = iter_q;
        out_valid_d = out_valid_q;
        out_high_d  = out_high_q;
        out_low_d   = out_low_q;
        flags_d     = flags_q;
        latch_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    op_d    = head_op_s;
                    a_d     = head_a_s;
                    b_d     = head_b_s;
                    hi_d    = '0;
                    lo_d    = (head_op_s == OP_MUL) ? head_b_s : head_a_s;
                    iter_d  = '0;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (is_iterative(op_q)) begin
                    iter_d = iter_q + IW'(1);
                    if (op_q == OP_MUL) begin
                        hi_d = mul_hi_s;
                        lo_d = mul_lo_s;
                    end else if (b_q != '0) begin
                        hi_d = div_rem_s;
                        lo_d = div_quo_s;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                    if (iter_q == LAST_ITER) begin
                        state_d = ST_RESULT;
                        latch_s = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_RESULT;
                    latch_s = 1'b1;
                end
            end
            ST_RESULT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (latch_s) begin
            out_valid_d = 1'b1;
            out_high_d  = fin_hi_s;
            out_low_d   = fin_lo_s;
            flags_d     = fin_flags_s;
        end else begin
            out_high_d = out_high_q;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
            out_high_q  <= '0;
            out_low_q   <= '0;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            iter_q      <= iter_d;
            out_valid_q <= out_valid_d;
            out_high_q  <= out_high_d;
            out_low_q   <= out_low_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.in_ready  = !fifo_full_s;
    assign bus.count     = fifo_count_s;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_high  = out_high_q;
    assign bus.out_low   = out_low_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_queued_seq_alu.sv
// Bench for queued_seq_alu: transaction-level reference model checked every
// cycle, plus directed latency/result cases and random traffic.
module tb_queued_seq_alu;
    localparam int W = 4;
    localparam int D = 4;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } cmd_t;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [3:0]   fl;
    } res_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    queued_seq_alu_if #(.WIDTH(W), .DEPTH(D)) bus ();

    queued_seq_alu #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        cmd_t c;
        c.op = op;
        c.a  = a;
        c.b  = b;
        return c;
    endfunction

    // Reference arithmetic straight from the operation definitions
    function automatic res_t alu_ref(input cmd_t c);
        res_t r;
        int a, b, m, s;
        a = int'(c.a);
        b = int'(c.b);
        m = 1 << W;
        r = '0;
        case (c.op)
            3'd0: begin s = a + b; r.lo = W'(s % m); r.hi = W'(s / m); r.fl[0] = (s >= m); end
            3'd1: begin r.lo = W'((a - b + m) % m); r.hi = (a < b) ? W'(1) : W'(0); r.fl[0] = (a < b); end
            3'd2: begin s = a * b; r.lo = W'(s % m); r.hi = W'(s / m); end
            3'd3: begin
                if (b == 0) begin r.lo = W'(m - 1); r.hi = c.a; r.fl[2] = 1'b1; end
                else begin r.lo = W'(a / b); r.hi = W'(a % b); end
            end
            3'd4: r.lo = c.a & c.b;
            3'd5: r.lo = c.a | c.b;
            3'd6: r.lo = c.a ^ c.b;
            default: r.fl[3] = 1'b1;
        endcase
        r.fl[1] = (c.op != 3'd7) && (r.hi == '0) && (r.lo == '0);
        return r;
    endfunction

    // Model: queue of waiting commands, engine free(0)/working(1)/holding(2)
    cmd_t mq[$];
    int   eng;
    int   timer;
    res_t cur;
    int   n_taken;

    initial begin
        eng = 0; timer = 0; cur = '0; n_taken = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
                eng = 0;
                cur = '0;
            end
            check("out_valid", 32'(bus.out_valid), 32'(eng == 2));
            check("busy", 32'(bus.busy), 32'(eng != 0));
            check("count", 32'(bus.count), 32'(mq.size()));
            check("in_ready", 32'(bus.in_ready), 32'(mq.size() < D));
            if (eng == 2 || reset) begin
                check("result", 32'({bus.out_high, bus.out_low, bus.flags}), 32'(cur));
            end
            if (!reset) begin
                bit   push;
                cmd_t c;
                push = bus.in_valid && (mq.size() < D);
                case (eng)
                    0: if (mq.size() > 0) begin
                        c = mq.pop_front();
                        cur = alu_ref(c);
                        timer = (c.op == 3'd2 || c.op == 3'd3) ? W : 1;
                        eng = 1;
                    end
                    1: begin
                        timer--;
                        if (timer == 0) eng = 2;
                    end
                    default: if (bus.out_ready) begin
                        eng = 0;
                        n_taken++;
                    end
                endcase
                if (push) mq.push_back(mk(bus.opcode, bus.in1, bus.in2));
            end
        end
    end

    task automatic run_one(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int exp_lat, input logic [11:0] exp_r);
        int lat;
        bit got;
        bus.in_valid = 1'b1; bus.opcode = op; bus.in1 = a; bus.in2 = b; bus.out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_rdy"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.opcode = 3'd7; bus.in1 = ~a; bus.in2 = ~b;
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); lat++; #1;
            got = bus.out_valid;
        end
        check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        check({nm, "_res"}, 32'({bus.out_high, bus.out_low, bus.flags}), 32'(exp_r));
        @(posedge clk); #1;
    endtask

    initial begin
        int  acc;
        int  n0;
        int  k;
        bit  seen;
        n_tests = 0; n_fail = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.opcode = 3'd0; bus.in1 = '0; bus.in2 = '0; bus.out_ready = 1'b0;

        check("pin_add",  32'(alu_ref(mk(3'd0, 4'd9, 4'd8))),   32'({4'd1, 4'd1, 4'b0001}));
        check("pin_sub",  32'(alu_ref(mk(3'd1, 4'd3, 4'd5))),   32'({4'd1, 4'd14, 4'b0001}));
        check("pin_mul",  32'(alu_ref(mk(3'd2, 4'd15, 4'd15))), 32'({4'd14, 4'd1, 4'b0000}));
        check("pin_div",  32'(alu_ref(mk(3'd3, 4'd13, 4'd4))),  32'({4'd1, 4'd3, 4'b0000}));
        check("pin_div0", 32'(alu_ref(mk(3'd3, 4'd7, 4'd0))),   32'({4'd7, 4'd15, 4'b0100}));
        check("pin_ill",  32'(alu_ref(mk(3'd7, 4'd5, 4'd3))),   32'({4'd0, 4'd0, 4'b1000}));
        check("pin_and",  32'(alu_ref(mk(3'd4, 4'd12, 4'd10))), 32'({4'd0, 4'd8, 4'b0000}));
        check("pin_subz", 32'(alu_ref(mk(3'd1, 4'd5, 4'd5))),   32'({4'd0, 4'd0, 4'b0010}));

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_outs", 32'({bus.out_valid, bus.out_high, bus.out_low, bus.flags, bus.count, bus.busy}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_one("add",  3'd0, 4'd9,  4'd8,  2, {4'd1, 4'd1, 4'b0001});
        run_one("sub",  3'd1, 4'd3,  4'd5,  2, {4'd1, 4'd14, 4'b0001});
        run_one("mul",  3'd2, 4'd15, 4'd15, 5, {4'd14, 4'd1, 4'b0000});
        run_one("mulz", 3'd2, 4'd0,  4'd9,  5, {4'd0, 4'd0, 4'b0010});
        run_one("div",  3'd3, 4'd13, 4'd4,  5, {4'd1, 4'd3, 4'b0000});
        run_one("div0", 3'd3, 4'd7,  4'd0,  5, {4'd7, 4'd15, 4'b0100});
        run_one("ill",  3'd7, 4'd5,  4'd3,  2, {4'd0, 4'd0, 4'b1000});
        run_one("xor",  3'd6, 4'd12, 4'd10, 2, {4'd0, 4'd6, 4'b0000});

        // Backpressure: six ADDs offered while the consumer stalls
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.opcode = 3'd0; bus.in1 = W'(i + 1); bus.in2 = W'(2 * i + 3);
            @(negedge clk);
            if (bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 32'(acc), 32'd5);
        check("bp_count", 32'(bus.count), 32'd4);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        n0 = n_taken;
        bus.out_ready = 1'b1;
        k = 0;
        while (n_taken - n0 < 5 && k < 80) begin
            @(posedge clk); #1; k++;
        end
        check("bp_results_taken", 32'(n_taken - n0), 32'd5);
        repeat (2) @(posedge clk);
        #1;

        // Reset pulsed while a MUL runs with two commands queued
        bus.in_valid = 1'b1; bus.opcode = 3'd2; bus.in1 = 4'd7; bus.in2 = 4'd6;
        @(posedge clk); #1;
        bus.opcode = 3'd0; bus.in1 = 4'd1; bus.in2 = 4'd2;
        @(posedge clk); #1;
        bus.opcode = 3'd1; bus.in1 = 4'd9; bus.in2 = 4'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        check("pre_rst_count", 32'(bus.count), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_outs", 32'({bus.out_valid, bus.out_high, bus.out_low, bus.flags, bus.count, bus.busy}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        check("no_stale", 32'(seen), 32'd0);

        // Random traffic with random consumer stalls
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 60);
            bus.opcode    = 3'($urandom_range(0, 7));
            bus.in1       = W'($urandom_range(0, 15));
            bus.in2       = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 99) < 70);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        k = 0;
        while ((mq.size() != 0 || eng != 0) && k < 300) begin
            @(posedge clk); #1; k++;
        end
        check("drained", 32'(mq.size() == 0 && eng == 0), 32'd1);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
